// File: rtl/histogram_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : histogram_accumulator_pkg
// Purpose  : Shared widths, FSM encoding and saturation constant for the
//            histogram accumulation stage and its upstream bin distributer.
// Revision : 1.0  initial release
// ============================================================================
package histogram_accumulator_pkg;

   // Default widths, common with the bin-address producer upstream
   localparam int ADDR_W_DEF  = 8;
   localparam int COUNT_W_DEF = 16;
   localparam int DROP_W_DEF  = 16;

   // Saturation value of a bin counter at the default width
   localparam logic [COUNT_W_DEF-1:0] COUNT_SAT_DEF = {COUNT_W_DEF{1'b1}};

   // Top-level sequencer states
   typedef enum logic [0:0] {
      ST_CLEARING = 1'b0,
      ST_RUN      = 1'b1
   } hist_state_t;

endpackage : histogram_accumulator_pkg
`default_nettype wire

// File: rtl/histogram_accumulator_ram.sv
`default_nettype none
// ============================================================================
// Module   : histogram_accumulator_ram
// Purpose  : Dual-port synchronous histogram RAM. Port A carries the RMW read
//            and the RMW/clear write; port B is a read-only host port. Both
//            reads are read-first against a same-cycle write.
// Revision : 1.0  initial release
// ============================================================================
module histogram_accumulator_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] a_addr,
   output logic [DATA_W-1:0] a_data,
   input  logic              b_en,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Port A: write plus free-running read (old data returned on collision)
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      a_data <= mem[a_addr];
   end

   // Port B: host read, output register holds its value between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_data <= '0;
      end else if (b_en) begin
         b_data <= mem[b_addr];
      end
   end

endmodule : histogram_accumulator_ram
`default_nettype wire

// File: rtl/histogram_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : histogram_accumulator
// Purpose  : Per-bin event counter with a pipelined read-modify-write path
//            (one event per clock), clear sequencer, saturation flag, dropped
//            event counter and an independent host read port.
// Revision : 1.0  initial release
// ============================================================================
module histogram_accumulator
   import histogram_accumulator_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int COUNT_W = COUNT_W_DEF,
   parameter int DROP_W  = DROP_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  Addr,
   input  logic               Memory_add,
   input  logic               clear_req,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [COUNT_W-1:0] rd_data,
   output logic               rd_valid,
   output logic               clear_busy,
   output logic               sat_flag,
   output logic [DROP_W-1:0]  drop_count
);

   localparam logic [COUNT_W-1:0] SAT_MAX  = {COUNT_W{1'b1}};
   localparam logic [DROP_W-1:0]  DROP_MAX = {DROP_W{1'b1}};

   hist_state_t        state, state_nxt;
   logic [ADDR_W-1:0]  clr_ptr;
   logic               in_clear;
   logic               enter_clear;
   logic               accept;

   logic               s1_valid;
   logic [ADDR_W-1:0]  s1_addr;
   logic               fwd_sel;
   logic [COUNT_W-1:0] fwd_data;
   logic               s1_wr_en;
   logic [COUNT_W-1:0] s1_old;
   logic [COUNT_W-1:0] s1_new;

   logic               ram_wr_en;
   logic [ADDR_W-1:0]  ram_wr_addr;
   logic [COUNT_W-1:0] ram_wr_data;
   logic [COUNT_W-1:0] ram_a_data;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_CLEARING;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: sweep all bins once, then run until a clear is requested
   always_comb begin
      state_nxt   = state;
      in_clear    = 1'b0;
      enter_clear = 1'b0;
      case (state)
         ST_CLEARING: begin
            in_clear = 1'b1;
            if (clr_ptr == {ADDR_W{1'b1}}) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (clear_req) begin
               enter_clear = 1'b1;
               state_nxt   = ST_CLEARING;
            end
         end
         default: state_nxt = ST_CLEARING;
      endcase
   end

   assign clear_busy = in_clear;
   // Events on the cycle a clear is accepted are discarded like clear-time events
   assign accept     = (state == ST_RUN) && Memory_add && !clear_req;

   // Clear pointer walks every bin and wraps back to 0 at the end of the sweep
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_ptr <= '0;
      end else if (in_clear) begin
         clr_ptr <= clr_ptr + 1'b1;
      end else begin
         clr_ptr <= '0;
      end
   end

   // S0 -> S1 pipeline registers, including the same-bin forwarding capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         fwd_sel  <= 1'b0;
         fwd_data <= '0;
      end else begin
         s1_valid <= accept;
         s1_addr  <= Addr;
         fwd_sel  <= accept && s1_wr_en && (Addr == s1_addr);
         fwd_data <= s1_new;
      end
   end

   // S1: the RAM read of this bin raced the previous write, so take the
   // forwarded value when the bins match; writeback only while running
   assign s1_wr_en = s1_valid && (state == ST_RUN);
   assign s1_old   = fwd_sel ? fwd_data : ram_a_data;
   assign s1_new   = (s1_old == SAT_MAX) ? SAT_MAX : s1_old + 1'b1;

   assign ram_wr_en   = in_clear || s1_wr_en;
   assign ram_wr_addr = in_clear ? clr_ptr : s1_addr;
   assign ram_wr_data = in_clear ? '0 : s1_new;

   // Saturation flag and dropped-event counter, both reset on entering a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_flag   <= 1'b0;
         drop_count <= '0;
      end else if (enter_clear) begin
         sat_flag   <= 1'b0;
         drop_count <= Memory_add ? DROP_W'(1) : '0;
      end else begin
         if (s1_wr_en && (s1_new == SAT_MAX)) begin
            sat_flag <= 1'b1;
         end
         if (in_clear && Memory_add && (drop_count != DROP_MAX)) begin
            drop_count <= drop_count + 1'b1;
         end
      end
   end

   // Host read strobe is a single-cycle pulse one cycle after the request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
      end
   end

   histogram_accumulator_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (COUNT_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ram_wr_en),
      .wr_addr (ram_wr_addr),
      .wr_data (ram_wr_data),
      .a_addr  (Addr),
      .a_data  (ram_a_data),
      .b_en    (rd_en),
      .b_addr  (rd_addr),
      .b_data  (rd_data)
   );

endmodule : histogram_accumulator
`default_nettype wire

// File: tb/tb_histogram_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_histogram_accumulator
// Purpose  : Directed self-checking bench for histogram_accumulator; host
//            reads push expected counts to a queue checked by a monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_histogram_accumulator;

   localparam int ADDR_W  = 8;
   localparam int COUNT_W = 4;
   localparam int DROP_W  = 16;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [ADDR_W-1:0]  Addr = '0;
   logic               Memory_add = 1'b0;
   logic               clear_req = 1'b0;
   logic               rd_en = 1'b0;
   logic [ADDR_W-1:0]  rd_addr = '0;
   logic [COUNT_W-1:0] rd_data;
   logic               rd_valid;
   logic               clear_busy;
   logic               sat_flag;
   logic [DROP_W-1:0]  drop_count;

   int errors = 0;
   int checks = 0;

   logic [COUNT_W-1:0] exp_q [$];
   logic [ADDR_W-1:0]  addr_q [$];
   logic [COUNT_W-1:0] mon_exp;
   logic [ADDR_W-1:0]  mon_addr;

   histogram_accumulator #(
      .ADDR_W  (ADDR_W),
      .COUNT_W (COUNT_W),
      .DROP_W  (DROP_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Addr       (Addr),
      .Memory_add (Memory_add),
      .clear_req  (clear_req),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .clear_busy (clear_busy),
      .sat_flag   (sat_flag),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic strobe(input logic [ADDR_W-1:0] a);
      Memory_add = 1'b1;
      Addr       = a;
      step();
      Memory_add = 1'b0;
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [COUNT_W-1:0] e);
      rd_en   = 1'b1;
      rd_addr = a;
      exp_q.push_back(e);
      addr_q.push_back(a);
      step();
      rd_en = 1'b0;
   endtask

   task automatic count_busy(input int start, output int n);
      n = start;
      while (clear_busy === 1'b1 && n < 1000) begin
         step();
         n++;
      end
   endtask

   // Scoreboard monitor: every read response is compared with the queue head
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got rd_valid with data %0d expected no read", rd_data);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_addr = addr_q.pop_front();
            if (rd_data !== mon_exp) begin
               errors++;
               $display("FAIL rd_bin_%0h: got %0d expected %0d", mon_addr, rd_data, mon_exp);
            end
         end
      end
   end

   initial begin
      int n;

      // Reset values
      repeat (3) step();
      check("rst_clear_busy", 32'(clear_busy), 1);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_sat_flag", 32'(sat_flag), 0);
      check("rst_drop_count", 32'(drop_count), 0);

      // Initial clear lasts exactly 256 cycles, then all bins read zero
      rst = 1'b0;
      count_busy(0, n);
      check("init_clear_len", n, 256);
      do_read(8'd0, 4'd0);
      do_read(8'd127, 4'd0);
      do_read(8'd255, 4'd0);

      // Back-to-back events to one bin
      repeat (5) strobe(8'h23);
      repeat (2) step();
      do_read(8'h23, 4'd5);
      do_read(8'h22, 4'd0);
      do_read(8'h24, 4'd0);

      // Interleaved bins with reads 1 and 2 cycles after the last strobe
      strobe(8'd3);
      strobe(8'd4);
      strobe(8'd3);
      strobe(8'd4);
      strobe(8'd3);
      do_read(8'd3, 4'd2);
      do_read(8'd3, 4'd3);
      do_read(8'd4, 4'd2);

      // Saturation at 15 with a 4-bit counter
      repeat (14) strobe(8'd9);
      repeat (2) step();
      check("sat_before_15th", 32'(sat_flag), 0);
      strobe(8'd9);
      step();
      check("sat_on_15th", 32'(sat_flag), 1);
      repeat (5) strobe(8'd9);
      repeat (2) step();
      check("sat_sticky", 32'(sat_flag), 1);
      do_read(8'd9, 4'd15);

      // Clear with traffic; a second clear_req mid-clear must be ignored
      repeat (7) strobe(8'd1);
      repeat (2) step();
      do_read(8'd1, 4'd7);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      check("clear_sat_reset", 32'(sat_flag), 0);
      repeat (10) strobe(8'd1);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      count_busy(11, n);
      check("clear_len", n, 256);
      check("clear_drop_count", 32'(drop_count), 10);
      check("clear_sat_after", 32'(sat_flag), 0);
      do_read(8'd1, 4'd0);
      do_read(8'd9, 4'd0);

      // Reset at clear pointer 100 restarts the full sweep
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (3) strobe(8'd7);
      repeat (97) step();
      check("midclear_busy", 32'(clear_busy), 1);
      check("midclear_drop", 32'(drop_count), 3);
      rst = 1'b1;
      step();
      check("midclear_rst_drop", 32'(drop_count), 0);
      rst = 1'b0;
      count_busy(0, n);
      check("rst_midclear_len", n, 256);

      // Normal operation resumes after the restarted clear
      strobe(8'h50);
      strobe(8'h50);
      repeat (2) step();
      do_read(8'h50, 4'd2);
      do_read(8'h23, 4'd0);

      repeat (3) step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_histogram_accumulator
`default_nettype wire
